// File: rtl/clk_gen_pkg.sv
// Shared types and helpers for the clk_gen divided-clock generator.
// STEP state exists only when CLK_GEN_STEP_EN is defined.
package clk_gen_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_RUN     = 2'd1
`ifdef CLK_GEN_STEP_EN
        ,
        ST_STEP    = 2'd2
`endif
    } clk_gen_state_t;

    function automatic int clamp_sel(input int sel, input int max_sel);
        return (sel > max_sel) ? max_sel : sel;
    endfunction

    // Terminal count for a half-period of 2^sel cycles; callers size it to CNT_W.
    function automatic logic [31:0] half_period(input int sel);
        return (32'd1 << sel) - 32'd1;
    endfunction

endpackage

// File: rtl/clk_gen_cnt.sv
// Prescaler counter for clk_gen: wraps at a run-time terminal count,
// with synchronous clear used while the clock is stopped.
module clk_gen_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [CNT_W-1:0] tc_val,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    assign tc = (count == tc_val);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_gen.sv
// Glitch-free divided clock with rise/fall strobes, run/stop control and,
// when CLK_GEN_STEP_EN is defined, single-period stepping from STOPPED.
module clk_gen
    import clk_gen_pkg::*;
#(
    parameter  int MAX_SEL = 7,
    parameter  int SEL_W   = 3,
    localparam int CNT_W   = MAX_SEL + 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [SEL_W-1:0] clk_sel,
    input  logic             stop_clk,
`ifdef CLK_GEN_STEP_EN
    input  logic             step,
`endif
    output logic             clk_out,
    output logic             clk_rise,
    output logic             clk_fall,
    output logic             running,
    output logic [SEL_W-1:0] sel_active
);

    clk_gen_state_t   state_q, state_d;
    logic [SEL_W-1:0] sel_d, sel_clamped;
    logic [CNT_W-1:0] tc_val;
    logic             clk_d, rise_d, fall_d;
    logic             cnt_en, cnt_clr, cnt_tc;

    assign sel_clamped = SEL_W'(clamp_sel(int'(clk_sel), MAX_SEL));
    assign tc_val      = CNT_W'(half_period(int'(sel_active)));
    assign running     = (state_q != ST_STOPPED);

    clk_gen_cnt #(.CNT_W(CNT_W)) u_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (cnt_en),
        .clr    (cnt_clr),
        .tc_val (tc_val),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_active;
        clk_d   = clk_out;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        cnt_en  = 1'b0;
        cnt_clr = 1'b0;
        case (state_q)
            ST_STOPPED: begin
                cnt_clr = 1'b1;
                clk_d   = 1'b0;
                if (!stop_clk) begin
                    sel_d   = sel_clamped;
                    state_d = ST_RUN;
                end
`ifdef CLK_GEN_STEP_EN
                else if (step) begin
                    sel_d   = sel_clamped;
                    state_d = ST_STEP;
                end
`endif
            end
            default: begin
                cnt_en = 1'b1;
                if (cnt_tc) begin
                    clk_d  = ~clk_out;
                    rise_d = ~clk_out;
                    fall_d = clk_out;
                    // Falling toggle closes a full period: the only safe point to retune or stop.
                    if (clk_out) begin
                        sel_d = sel_clamped;
                        if (stop_clk) state_d = ST_STOPPED;
`ifdef CLK_GEN_STEP_EN
                        if (state_q == ST_STEP) begin
                            sel_d   = sel_active;
                            state_d = ST_STOPPED;
                        end
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q    <= ST_RUN;
            sel_active <= '0;
            clk_out    <= 1'b0;
            clk_rise   <= 1'b0;
            clk_fall   <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_active <= sel_d;
            clk_out    <= clk_d;
            clk_rise   <= rise_d;
            clk_fall   <= fall_d;
        end
    end

endmodule

// File: doc/clk_gen.md
# clk_gen

Parametrised successor to the CPU clock block: derives a divided, glitch-free `clk_out` from the single system clock, with a run-time selectable divide ratio, a clean stop/start, and optional single-stepping for debug. It also provides one-cycle rise and fall strobes in the `clk` domain so `cpu_top` and peripherals can use clock enables instead of the derived clock. Sits between the board clock input and `cpu_top`, replacing the fixed 3-bit selector block.

## Interface
- `MAX_SEL`, default 7: highest legal divide select; the half-period is 2^sel `clk` cycles.
- `SEL_W`, default 3: width of `clk_sel`; must satisfy 2^SEL_W > MAX_SEL.
- `CNT_W`, derived as MAX_SEL+1: prescaler counter width.

Ports:
- `clk` in 1: system clock. Single clock domain.
- `arst_n` in 1: reset, asynchronous, active-low.
- `clk_sel` in SEL_W: requested divide select; values above MAX_SEL clamp to MAX_SEL.
- `stop_clk` in 1: level request to stop `clk_out` low.
- `step` in 1: single-step request pulse; present only with `CLK_GEN_STEP_EN`.
- `clk_out` out 1: divided clock, registered.
- `clk_rise` out 1: one-cycle strobe, high in the cycle `clk_out` becomes 1.
- `clk_fall` out 1: one-cycle strobe, high in the cycle `clk_out` becomes 0.
- `running` out 1: high while in RUN or STEP.
- `sel_active` out SEL_W: divide select currently in effect.

## Operation
- States: STOPPED, RUN, and STEP (STEP exists only with the macro).
- Reset values: state RUN, `clk_out` 0, count 0, `sel_active` 0, all strobes 0, `running` 1.
- RUN: count increments each `clk`. When count reaches 2^sel_active−1, count goes to 0 and `clk_out` toggles.
- Parameter changes are taken only at a falling toggle, which is the end of a full period:
  - `clk_sel` (clamped) is sampled into `sel_active`.
  - `stop_clk` is sampled. If it is 1, the state goes to STOPPED.
  - Result: no high or low phase is ever shortened, so there are no glitches.
- STOPPED: `clk_out` is held 0 and count is held 0.
  - When `stop_clk` is 0, `clk_sel` is sampled into `sel_active` and the state goes to RUN.
  - The first low phase then runs its full length.
- Simultaneous events:
  - `stop_clk` rising during a high phase: the period completes.
  - `clk_sel` change during any phase: ignored until the next falling toggle.
  - A `stop_clk` pulse that falls before the falling toggle is lost. This is intended.
- Reset mid-period: `clk_out` drops to 0 immediately and asynchronously; no strobe is generated.

## Timing
- Period is 2^(sel_active+1) `clk` cycles with 50 % duty cycle. Example: sel 0 gives `clk_out` toggling every cycle.
- `clk_rise`/`clk_fall` are registered and coincide exactly with the `clk_out` register update.
- After STOPPED to RUN, the first `clk_rise` comes 2^sel cycles after the cycle in which `stop_clk` is seen low.
- `running` updates in the same cycle as the state register.

## Configuration
- `CLK_GEN_STEP_EN` defined:
  - In STOPPED, a `step` pulse samples `clk_sel` and enters STEP.
  - STEP behaves like RUN for exactly one full period: a low phase, a high phase, then the falling toggle.
  - After that falling toggle the state returns to STOPPED, regardless of `stop_clk`.
  - `step` outside STOPPED is ignored.
- Undefined: the `step` port and the STEP state do not exist, and the block only runs or stops.

## Structure
- Package `clk_gen_pkg`:
  - state enum `clk_gen_state_t`.
  - function `clamp_sel`.
  - function `half_period(sel)` returning a CNT_W-bit terminal count.
- One sub-module is natural: `clk_gen_cnt`, the prescaler counter with terminal-count compare and synchronous clear. The FSM, output register and strobes stay in `clk_gen`.

## Test plan
- Reset released with sel 0 and stop 0 → `clk_out` 0,1,0,1…. `clk_rise` every 2nd cycle. First rise 1 cycle after reset release.
- sel 2 → `clk_out` high 4 and low 4 cycles. `clk_rise` and `clk_fall` are single-cycle and 4 cycles apart.
- During a sel 2 high phase, `clk_sel` changes to 0 → that high phase still lasts 4 cycles, then the new period lasts 2 cycles. `sel_active` updates at the fall.
- `clk_sel` = 7 with MAX_SEL 5 → `sel_active` is 5 and half-period is 32.
- `stop_clk` asserted mid-high at sel 1 → the high phase finishes (2 cycles). `running` and `clk_out` are both 0 after the fall, with no further strobes. Deasserting `stop_clk` gives `clk_rise` 2 cycles later.
- With `CLK_GEN_STEP_EN`, `step` while STOPPED at sel 1 → exactly one `clk_rise` and one `clk_fall`, then back to STOPPED. Separately, `arst_n` low mid-high-phase forces `clk_out` to 0 immediately.
